// File: rtl/arm_register_file_pkg.sv
// Shared constants for the ARM register file: architectural register indices,
// default widths and the read-side PC offset.
package arm_register_file_pkg;

    localparam int ARM_DATA_W = 32;
    localparam int ARM_ADDR_W = 4;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    // Reading R15 shows the PC two instructions ahead (ARM pipeline view).
    localparam logic [31:0] ARM_PC_RD_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        RD_STORED = 2'd0,
        RD_PC     = 2'd1,
        RD_BYPASS = 2'd2
    } rd_src_e;

    function automatic rd_src_e rd_source(input logic       bypass_en,
                                          input logic       wr_en,
                                          input logic [3:0] wr_addr,
                                          input logic [3:0] rd_addr);
        rd_source = RD_STORED;
        if (bypass_en && wr_en && (wr_addr == rd_addr))
            rd_source = RD_BYPASS;
        else if (rd_addr == REG_PC)
            rd_source = RD_PC;
    endfunction

endpackage

// File: rtl/arm_register_file_decoder.sv
// Write-index decoder: turns a register index plus enable into one-hot write strobes.
module decoder_4to16
    import arm_register_file_pkg::*;
#(
    parameter int ADDR_W = ARM_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [(2**ADDR_W)-1:0] strobe
);

    always_comb begin
        strobe       = '0;
        strobe[addr] = en;
    end

endmodule

// File: rtl/arm_register_file.sv
// 16 x 32-bit ARM register file with R15 as the PC: two combinational read ports,
// one clocked write port, and a separate PC load path.
module arm_register_file
    import arm_register_file_pkg::*;
#(
    parameter int                DATA_W       = ARM_DATA_W,
    parameter int                ADDR_W       = ARM_ADDR_W,
    parameter logic [DATA_W-1:0] PC_RD_OFFSET = ARM_PC_RD_OFFSET,
    parameter bit                WRITE_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_ld,
    input  logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] pc_out
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   gpr [NUM_REGS-1];
    logic [DATA_W-1:0]   pc;
    logic [NUM_REGS-1:0] wr_strobe;
    logic [DATA_W-1:0]   pc_rd;
    logic [DATA_W-1:0]   ra_sel;
    logic [DATA_W-1:0]   rb_sel;
    rd_src_e             ra_src;
    rd_src_e             rb_src;

    decoder_4to16 #(
        .ADDR_W (ADDR_W)
    ) u_wr_decoder (
        .addr   (wr_addr),
        .en     (wr_en),
        .strobe (wr_strobe)
    );

    // A general write to R15 beats pc_ld: that is a branch through a data-processing op.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++)
                gpr[i] <= '0;
            pc <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++)
                if (wr_strobe[i])
                    gpr[i] <= wr_data;
            if (wr_strobe[NUM_REGS-1])
                pc <= wr_data;
            else if (pc_ld)
                pc <= pc_next;
        end
    end

    assign pc_out = pc;
    assign pc_rd  = pc + PC_RD_OFFSET;

    always_comb begin
        ra_sel = pc_rd;
        rb_sel = pc_rd;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (ra_addr == i[ADDR_W-1:0])
                ra_sel = gpr[i];
            if (rb_addr == i[ADDR_W-1:0])
                rb_sel = gpr[i];
        end
    end

    // Bypass stage sits after the 16:1 selects so a bypassed R15 read carries no offset.
    always_comb begin
        ra_src  = rd_source(WRITE_BYPASS, wr_en, wr_addr, ra_addr);
        rb_src  = rd_source(WRITE_BYPASS, wr_en, wr_addr, rb_addr);
        ra_data = (ra_src == RD_BYPASS) ? wr_data : ra_sel;
        rb_data = (rb_src == RD_BYPASS) ? wr_data : rb_sel;
    end

endmodule
